ac_lane_dispatcher: RTL and testbench
=====================================

# ac_lane_dispatcher

Multi-lane stream dispatcher between the upsampling input AXI-Stream and N_LANES parallel bicubic processing elements. Input pixels are distributed round-robin across lanes. Lane results are re-collected in the same round-robin order into one output AXI-Stream. The block counts input and output handshakes against configured frame totals and emits a completion pulse. It generalises the single-PE access-control path to a configurable lane count with per-lane output buffering.

## Interface
**Parameters**
- N_LANES, 4: number of processing-element lanes (≥1, power of two not required).
- IN_DATA_WIDTH, 24: input stream / lane read data width.
- OUT_DATA_WIDTH, 24: lane write / output stream data width.
- FIFO_DEPTH, 4: per-lane output FIFO depth (≥2, power of two).
- CNT_WIDTH, 32: frame counter width.

**Ports** (one clock; reset is asynchronous and active-high)
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- start, in, 1: single-cycle frame start.
- in_total, in, CNT_WIDTH: input beats per frame; sampled at start.
- out_total, in, CNT_WIDTH: output beats per frame; sampled at start.
- busy, out, 1: high in RUN.
- done, out, 1: one-cycle pulse at frame end.
- in_cnt, out, CNT_WIDTH: accepted input beats.
- out_cnt, out, CNT_WIDTH: emitted output beats.
- s_axis_tvalid, in, 1; s_axis_tready, out, 1; s_axis_tdata, in, IN_DATA_WIDTH: input stream.
- lane_rvalid, out, N_LANES; lane_rready, in, N_LANES; lane_rdata, out, N_LANES*IN_DATA_WIDTH: per-lane reads, lane i in slice i.
- lane_wvalid, in, N_LANES; lane_wready, out, N_LANES; lane_wdata, in, N_LANES*OUT_DATA_WIDTH: per-lane writes.
- m_axis_tvalid, out, 1; m_axis_tready, in, 1; m_axis_tdata, out, OUT_DATA_WIDTH; m_axis_tlast, out, 1: output stream.

## Operation
- FSM has two states: IDLE and RUN.
- **IDLE → RUN:** on start with in_total≠0 and out_total≠0. On this transition:
  - latch the totals;
  - clear in_cnt, out_cnt, in_ptr and out_ptr;
  - flush all FIFOs.
- start in IDLE with either total equal to 0 is ignored (no done).
- start in RUN is ignored.
- **Dispatch (RUN only):**
  - all lanes receive s_axis_tdata on lane_rdata;
  - lane_rvalid[in_ptr] = s_axis_tvalid && in_cnt<in_total; other lanes' rvalid = 0;
  - s_axis_tready = lane_rready[in_ptr] && in_cnt<in_total.
  - On handshake: in_cnt+1, and in_ptr advances, wrapping N_LANES-1 → 0.
- **Collect:**
  - lane_wready[i] = RUN && !full[i];
  - a lane write pushes into FIFO i.
  - m_axis_tvalid = RUN && !empty[out_ptr] && out_cnt<out_total;
  - m_axis_tdata = head of FIFO out_ptr.
  - On handshake: pop, out_cnt+1, and out_ptr advances with wrap.
  - Output order is strictly lane 0,1,…,N_LANES-1,0,… even if other FIFOs hold data.
- m_axis_tlast = m_axis_tvalid && out_cnt==out_total-1.
- **RUN → IDLE:** on the handshake that brings out_cnt to out_total. done pulses the following cycle.
- **Frame-end cleanup:** lane writes arriving after the frame ends are back-pressured (wready=0). FIFO residue is discarded at the next start.
- **Counter limits:** in_cnt and out_cnt saturate at the latched totals.
- **Reset values:** all outputs are 0 during/after reset (tready, rvalid, wready, tvalid, tlast, busy, done, counters); FSM returns to IDLE; FIFOs are emptied. Reset mid-frame aborts with no done.

## Timing
- The input path is combinational: zero latency from s_axis to lane_rvalid/lane_rdata, with no registered stage.
- Each FIFO is registered and not first-word-fall-through. A lane write in cycle t becomes visible at the FIFO head in t+1.
- Simultaneous push and pop on the same FIFO is legal when not full; occupancy is unchanged.
- A full FIFO deasserts its wready in the same cycle it becomes full (registered full flag).
- Sustained throughput is 1 output beat/cycle, given every lane keeps its FIFO non-empty.
- busy rises the cycle after start and falls in the cycle done is high.
- The AXI-Stream rule holds: once m_axis_tvalid is asserted, tdata and tlast stay stable until tready.

## Configuration
- **AC_LANE_PERF_EN defined:** adds ports perf_istall (out, CNT_WIDTH) and perf_ostall (out, CNT_WIDTH), both cleared at start.
  - perf_istall counts RUN cycles with s_axis_tvalid && !s_axis_tready && in_cnt<in_total.
  - perf_ostall counts RUN cycles with m_axis_tvalid && !m_axis_tready.
  - Both saturate at all-ones.
- **AC_LANE_PERF_EN undefined:** the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- **Shared package ac_pkg:**
  - state enum (AC_LD_IDLE, AC_LD_RUN);
  - default width constants;
  - a pointer-increment-with-wrap function.
- **Sub-module ac_lane_fifo:** synchronous FIFO, parameters WIDTH and DEPTH, with push/pop/full/empty/flush. It is instantiated N_LANES times via generate.

## Test plan
- N_LANES=4, in_total=8, out_total=32; each lane model returns 4 beats per input (value = in_data*16 + k) → 32 output beats in order lane0…lane3 repeating, tlast only on beat 32, done one cycle after it, in_cnt=8.
- Lane 2 holds rready=0 for 10 cycles after in_cnt=2 → s_axis_tready=0 for those 10 cycles, no beat reaches lanes 0/1/3, and dispatch resumes to lane 2.
- m_axis_tready=0 for 20 cycles mid-frame with FIFO_DEPTH=4 → every lane's wready drops after 4 pushes, no data lost, tdata stable while stalled.
- start with in_total=0 → stays IDLE, busy=0, no done; a second start while in RUN → no effect on counters.
- rst asserted at out_cnt=5 → all outputs 0 immediately and no done. A new start then runs a full frame correctly from out_cnt=0.
- AC_LANE_PERF_EN defined, m_axis_tready low for 7 cycles while tvalid=1 → perf_ostall=7 at done.

Source files
------------

// File: rtl/ac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ac_pkg                                                          |
// | Purpose  : Shared types, default widths and helpers for the multi-lane     |
// |            access-control dispatcher (ac_lane_dispatcher, ac_lane_fifo).   |
// | Contents : ac_ld_state_t   - dispatcher FSM state encoding                 |
// |            c_def_*         - default parameter values                      |
// |            ac_ptr_inc()    - lane pointer increment with wrap              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ac_pkg;

   typedef enum logic [0:0] {
      AC_LD_IDLE = 1'b0,
      AC_LD_RUN  = 1'b1
   } ac_ld_state_t;

   localparam int c_def_n_lanes        = 4;
   localparam int c_def_in_data_width  = 24;
   localparam int c_def_out_data_width = 24;
   localparam int c_def_fifo_depth     = 4;
   localparam int c_def_cnt_width      = 32;

   // Next round-robin lane index; wraps the last lane back to lane 0.
   function automatic int unsigned ac_ptr_inc(input int unsigned ptr,
                                              input int unsigned n_lanes);
      if (ptr >= n_lanes - 1) begin
         return 0;
      end
      return ptr + 1;
   endfunction

endpackage : ac_pkg
`default_nettype wire

// File: rtl/ac_lane_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ac_lane_fifo                                                    |
// | Purpose  : Synchronous per-lane output FIFO. Registered storage, not       |
// |            first-word-fall-through: a push in cycle t is visible at the    |
// |            head in t+1. full/empty are registered flags.                   |
// | Ports    : clk, rst        - clock, asynchronous active-high reset         |
// |            flush           - synchronous empty (discards contents)         |
// |            push, wdata     - write side (ignored while full)               |
// |            pop, rdata      - read side, rdata is the current head          |
// |            full, empty     - occupancy flags                               |
// | Params   : WIDTH - data width, DEPTH - entries (>=2, power of two)         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ac_lane_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_do_push;
   logic             w_do_pop;
   logic [c_aw:0]    w_count_nxt;

   assign w_do_push = push && !r_full && !flush;
   assign w_do_pop  = pop && !r_empty && !flush;

   always_comb begin
      w_count_nxt = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (c_aw + 1)'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   assign rdata = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;

endmodule : ac_lane_fifo
`default_nettype wire

// File: rtl/ac_lane_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ac_lane_dispatcher                                              |
// | Purpose  : Round-robin dispatch of an input AXI-Stream across N_LANES      |
// |            processing elements and in-order re-collection of their         |
// |            results through per-lane FIFOs into one output AXI-Stream.      |
// |            Counts input/output beats against per-frame totals and pulses   |
// |            done when the last output beat is accepted.                     |
// | Ports    : clk, rst                 - clock, async active-high reset       |
// |            start, in_total,         - frame control (totals sampled at     |
// |            out_total                  start)                               |
// |            busy, done               - frame status                         |
// |            in_cnt, out_cnt          - accepted / emitted beat counts       |
// |            s_axis_*                 - input stream                         |
// |            lane_r*                  - per-lane read channel (lane i slice) |
// |            lane_w*                  - per-lane write channel               |
// |            m_axis_*                 - output stream                        |
// |            perf_istall, perf_ostall - stall counters (AC_LANE_PERF_EN)     |
// | Config   : `define AC_LANE_PERF_EN adds the stall performance counters.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ac_lane_dispatcher
   import ac_pkg::*;
#(
   parameter int N_LANES        = c_def_n_lanes,
   parameter int IN_DATA_WIDTH  = c_def_in_data_width,
   parameter int OUT_DATA_WIDTH = c_def_out_data_width,
   parameter int FIFO_DEPTH     = c_def_fifo_depth,
   parameter int CNT_WIDTH      = c_def_cnt_width
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [CNT_WIDTH-1:0]              in_total,
   input  logic [CNT_WIDTH-1:0]              out_total,
   output logic                              busy,
   output logic                              done,
   output logic [CNT_WIDTH-1:0]              in_cnt,
   output logic [CNT_WIDTH-1:0]              out_cnt,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic [IN_DATA_WIDTH-1:0]          s_axis_tdata,
   output logic [N_LANES-1:0]                lane_rvalid,
   input  logic [N_LANES-1:0]                lane_rready,
   output logic [N_LANES*IN_DATA_WIDTH-1:0]  lane_rdata,
   input  logic [N_LANES-1:0]                lane_wvalid,
   output logic [N_LANES-1:0]                lane_wready,
   input  logic [N_LANES*OUT_DATA_WIDTH-1:0] lane_wdata,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [OUT_DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                              m_axis_tlast
`ifdef AC_LANE_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0]              perf_istall,
   output logic [CNT_WIDTH-1:0]              perf_ostall
`endif
);

   localparam int c_ptr_w = (N_LANES > 1) ? $clog2(N_LANES) : 1;

   ac_ld_state_t         r_state;
   logic [CNT_WIDTH-1:0] r_in_total;
   logic [CNT_WIDTH-1:0] r_out_total;
   logic [CNT_WIDTH-1:0] r_in_cnt;
   logic [CNT_WIDTH-1:0] r_out_cnt;
   logic [c_ptr_w-1:0]   r_in_ptr;
   logic [c_ptr_w-1:0]   r_out_ptr;
   logic                 r_done;

   logic                      w_run;
   logic                      w_start_ok;
   logic                      w_in_room;
   logic                      w_out_room;
   logic                      w_in_hs;
   logic                      w_out_hs;
   logic                      w_last_beat;
   logic [N_LANES-1:0]        w_full;
   logic [N_LANES-1:0]        w_empty;
   logic [N_LANES-1:0]        w_push;
   logic [N_LANES-1:0]        w_pop;
   logic [OUT_DATA_WIDTH-1:0] w_head [N_LANES];

   assign w_run      = (r_state == AC_LD_RUN);
   assign w_start_ok = (r_state == AC_LD_IDLE) && start &&
                       (in_total != '0) && (out_total != '0);
   // Counters stop at the latched totals because no handshake is offered
   // once they are reached.
   assign w_in_room  = (r_in_cnt < r_in_total);
   assign w_out_room = (r_out_cnt < r_out_total);

   // ------------------------------------------------------------------
   // Input dispatch: purely combinational, only the lane under in_ptr
   // sees a valid beat.
   // ------------------------------------------------------------------
   assign s_axis_tready = w_run && w_in_room && lane_rready[r_in_ptr];
   assign w_in_hs       = s_axis_tvalid && s_axis_tready;
   assign lane_rdata    = {N_LANES{s_axis_tdata}};

   always_comb begin
      lane_rvalid           = '0;
      lane_rvalid[r_in_ptr] = w_run && w_in_room && s_axis_tvalid;
   end

   // ------------------------------------------------------------------
   // Per-lane result buffering
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
         assign lane_wready[gi] = w_run && !w_full[gi];
         assign w_push[gi]      = lane_wvalid[gi] && lane_wready[gi];
         assign w_pop[gi]       = w_out_hs && (r_out_ptr == c_ptr_w'(gi));

         ac_lane_fifo #(
            .WIDTH (OUT_DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (w_start_ok),
            .push  (w_push[gi]),
            .wdata (lane_wdata[gi*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]),
            .pop   (w_pop[gi]),
            .rdata (w_head[gi]),
            .full  (w_full[gi]),
            .empty (w_empty[gi])
         );
      end
   endgenerate

   // ------------------------------------------------------------------
   // Output collection: strictly in lane order, waiting on out_ptr's
   // FIFO even when other lanes already hold data.
   // ------------------------------------------------------------------
   assign m_axis_tvalid = w_run && w_out_room && !w_empty[r_out_ptr];
   // Head only moves on a pop, so tdata/tlast hold while stalled.
   assign m_axis_tdata  = m_axis_tvalid ? w_head[r_out_ptr] : '0;
   assign m_axis_tlast  = m_axis_tvalid && (r_out_cnt == r_out_total - 1'b1);
   assign w_out_hs      = m_axis_tvalid && m_axis_tready;
   assign w_last_beat   = w_out_hs && (r_out_cnt == r_out_total - 1'b1);

   // ------------------------------------------------------------------
   // Frame control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= AC_LD_IDLE;
         r_in_total  <= '0;
         r_out_total <= '0;
         r_in_cnt    <= '0;
         r_out_cnt   <= '0;
         r_in_ptr    <= '0;
         r_out_ptr   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            AC_LD_IDLE: begin
               if (w_start_ok) begin
                  r_state     <= AC_LD_RUN;
                  r_in_total  <= in_total;
                  r_out_total <= out_total;
                  r_in_cnt    <= '0;
                  r_out_cnt   <= '0;
                  r_in_ptr    <= '0;
                  r_out_ptr   <= '0;
               end
            end
            AC_LD_RUN: begin
               if (w_in_hs) begin
                  r_in_cnt <= r_in_cnt + 1'b1;
                  r_in_ptr <= c_ptr_w'(ac_ptr_inc(32'(r_in_ptr), 32'(N_LANES)));
               end
               if (w_out_hs) begin
                  r_out_cnt <= r_out_cnt + 1'b1;
                  r_out_ptr <= c_ptr_w'(ac_ptr_inc(32'(r_out_ptr), 32'(N_LANES)));
               end
               if (w_last_beat) begin
                  r_state <= AC_LD_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= AC_LD_IDLE;
         endcase
      end
   end

   assign busy    = w_run;
   assign done    = r_done;
   assign in_cnt  = r_in_cnt;
   assign out_cnt = r_out_cnt;

`ifdef AC_LANE_PERF_EN
   // ------------------------------------------------------------------
   // Stall counters, cleared on an accepted start, saturating at all-ones
   // ------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] r_perf_istall;
   logic [CNT_WIDTH-1:0] r_perf_ostall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_istall <= '0;
         r_perf_ostall <= '0;
      end else if (w_start_ok) begin
         r_perf_istall <= '0;
         r_perf_ostall <= '0;
      end else if (w_run) begin
         if (s_axis_tvalid && !s_axis_tready && w_in_room && (r_perf_istall != '1)) begin
            r_perf_istall <= r_perf_istall + 1'b1;
         end
         if (m_axis_tvalid && !m_axis_tready && (r_perf_ostall != '1)) begin
            r_perf_ostall <= r_perf_ostall + 1'b1;
         end
      end
   end

   assign perf_istall = r_perf_istall;
   assign perf_ostall = r_perf_ostall;
`endif

endmodule : ac_lane_dispatcher
`default_nettype wire

// File: tb/tb_ac_lane_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ac_lane_dispatcher                                           |
// | Purpose  : Directed self-checking bench for ac_lane_dispatcher with four   |
// |            lane models that return four beats (in*16+k) per input.         |
// | Config   : AC_LANE_PERF_EN enables the stall-counter scenario.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ac_lane_dispatcher;

   localparam int c_lanes = 4;
   localparam int c_dw    = 24;
   localparam int c_cw    = 32;

   logic                      clk;
   logic                      rst;
   logic                      start;
   logic [c_cw-1:0]           in_total;
   logic [c_cw-1:0]           out_total;
   logic                      busy;
   logic                      done;
   logic [c_cw-1:0]           in_cnt;
   logic [c_cw-1:0]           out_cnt;
   logic                      s_axis_tvalid;
   logic                      s_axis_tready;
   logic [c_dw-1:0]           s_axis_tdata;
   logic [c_lanes-1:0]        lane_rvalid;
   logic [c_lanes-1:0]        lane_rready;
   logic [c_lanes*c_dw-1:0]   lane_rdata;
   logic [c_lanes-1:0]        lane_wvalid;
   logic [c_lanes-1:0]        lane_wready;
   logic [c_lanes*c_dw-1:0]   lane_wdata;
   logic                      m_axis_tvalid;
   logic                      m_axis_tready;
   logic [c_dw-1:0]           m_axis_tdata;
   logic                      m_axis_tlast;
`ifdef AC_LANE_PERF_EN
   logic [c_cw-1:0]           perf_istall;
   logic [c_cw-1:0]           perf_ostall;
`endif

   ac_lane_dispatcher #(
      .N_LANES        (c_lanes),
      .IN_DATA_WIDTH  (c_dw),
      .OUT_DATA_WIDTH (c_dw),
      .FIFO_DEPTH     (4),
      .CNT_WIDTH      (c_cw)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .in_total      (in_total),
      .out_total     (out_total),
      .busy          (busy),
      .done          (done),
      .in_cnt        (in_cnt),
      .out_cnt       (out_cnt),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .lane_rvalid   (lane_rvalid),
      .lane_rready   (lane_rready),
      .lane_rdata    (lane_rdata),
      .lane_wvalid   (lane_wvalid),
      .lane_wready   (lane_wready),
      .lane_wdata    (lane_wdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast)
`ifdef AC_LANE_PERF_EN
      ,
      .perf_istall   (perf_istall),
      .perf_ostall   (perf_ostall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Environment state shared by the driver and the scenario tasks
   logic [c_dw-1:0] src_q[$];
   bit              sink_ready;
   logic [3:0]      lane_hold;
   logic [c_dw-1:0] lane_buf [c_lanes][64];
   int              lane_wp [c_lanes];
   int              lane_rp [c_lanes];
   bit              f_in;
   bit [3:0]        f_rd;
   bit [3:0]        f_wr;
   logic [c_dw-1:0] rd_val [c_lanes];
   bit              f_out;
   logic [c_dw-1:0] out_d;
   bit              out_l;
   int              out_c;
   logic [c_dw-1:0] got_data[$];
   bit              got_last[$];
   int              got_cyc[$];
   int              cyc = 0;
   int              done_cnt = 0;
   int              done_cyc = 0;

   // Driver: at each falling edge apply the handshakes of the previous rising
   // edge, drive new inputs, then flag the handshakes for the next edge.
   initial begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      lane_rready   = '0;
      lane_wvalid   = '0;
      lane_wdata    = '0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < c_lanes; i++) begin
         lane_wp[i] = 0;
         lane_rp[i] = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            f_in  = 1'b0;
            f_rd  = '0;
            f_wr  = '0;
            f_out = 1'b0;
            for (int i = 0; i < c_lanes; i++) begin
               lane_wp[i] = 0;
               lane_rp[i] = 0;
            end
         end else begin
            if (f_in && src_q.size() > 0) void'(src_q.pop_front());
            for (int i = 0; i < c_lanes; i++) begin
               if (f_rd[i]) begin
                  for (int k = 0; k < 4; k++) begin
                     lane_buf[i][lane_wp[i] % 64] = c_dw'(rd_val[i] * 16 + k);
                     lane_wp[i]++;
                  end
               end
               if (f_wr[i]) lane_rp[i]++;
            end
            if (f_out) begin
               got_data.push_back(out_d);
               got_last.push_back(out_l);
               got_cyc.push_back(out_c);
            end
         end
         s_axis_tvalid = (src_q.size() > 0);
         s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
         for (int i = 0; i < c_lanes; i++) begin
            lane_rready[i] = !lane_hold[i];
            lane_wvalid[i] = (lane_wp[i] != lane_rp[i]);
            lane_wdata[i*c_dw +: c_dw] = lane_buf[i][lane_rp[i] % 64];
         end
         m_axis_tready = sink_ready;
         #1;
         f_in = s_axis_tvalid && s_axis_tready;
         for (int i = 0; i < c_lanes; i++) begin
            f_rd[i]   = lane_rvalid[i] && lane_rready[i];
            rd_val[i] = lane_rdata[i*c_dw +: c_dw];
            f_wr[i]   = lane_wvalid[i] && lane_wready[i];
         end
         f_out = m_axis_tvalid && m_axis_tready;
         out_d = m_axis_tdata;
         out_l = m_axis_tlast;
         out_c = cyc;
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected output beat n for a frame whose inputs are base, base+1, ...
   function automatic logic [c_dw-1:0] exp_beat(input int base, input int n);
      int l;
      int m;
      int j;
      l = n % 4;
      m = n / 4;
      j = l + 4 * (m / 4);
      return c_dw'((base + j) * 16 + (m % 4));
   endfunction

   task automatic load_src(input int base, input int first, input int count);
      for (int j = first; j < first + count; j++) src_q.push_back(c_dw'(base + j));
   endtask

   task automatic pulse_start(input logic [c_cw-1:0] it, input logic [c_cw-1:0] ot);
      @(negedge clk); #2;
      in_total  = it;
      out_total = ot;
      start     = 1'b1;
      @(negedge clk); #2;
      start     = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      int d0;
      d0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk); #2;
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic clear_capture();
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      n_tests++;
      if ({busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 00000", {busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast});
      end
      n_tests++;
      if ({lane_rvalid, lane_wready} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_lanes: got %h required 00", {lane_rvalid, lane_wready});
      end
      n_tests++;
      if (in_cnt !== 0 || out_cnt !== 0) begin
         n_fail++;
         $display("FAIL reset_cnt: got in=%0d out=%0d required 0/0", in_cnt, out_cnt);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frame();
      bit ok;
      clear_capture();
      load_src(1, 0, 8);
      pulse_start(8, 32);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_busy: got %b required 1", busy);
      end
      wait_done(400, ok);
      n_tests++;
      if (!ok || got_data.size() != 32) begin
         n_fail++;
         $display("FAIL frame_done: done=%0d beats=%0d required 1/32", ok, got_data.size());
      end else begin
         for (int n = 0; n < 32; n++) begin
            n_tests++;
            if (got_data[n] !== exp_beat(1, n) || got_last[n] !== (n == 31)) begin
               n_fail++;
               $display("FAIL frame_beat%0d: got %h/%b required %h/%b", n, got_data[n], got_last[n], exp_beat(1, n), n == 31);
            end
         end
         n_tests++;
         if (done_cyc != got_cyc[31] + 1) begin
            n_fail++;
            $display("FAIL frame_done_timing: got cycle %0d required %0d", done_cyc, got_cyc[31] + 1);
         end
      end
      n_tests++;
      if (in_cnt !== 8 || out_cnt !== 32 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_end_state: got in=%0d out=%0d busy=%b required 8/32/0", in_cnt, out_cnt, busy);
      end
   endtask

   task automatic test_lane_stall();
      bit ok;
      bit hit;
      clear_capture();
      lane_hold = 4'b0100;
      load_src(64, 0, 8);
      pulse_start(8, 32);
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #2;
         if (in_cnt == 2) begin
            hit = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!hit) begin
         n_fail++;
         $display("FAIL lstall_reach: in_cnt=%0d required 2", in_cnt);
      end
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            @(negedge clk); #2;
         end
         n_tests++;
         if (s_axis_tready !== 1'b0 || lane_rvalid !== 4'b0100 || in_cnt !== 2) begin
            n_fail++;
            $display("FAIL lstall_hold%0d: got tready=%b rvalid=%b in=%0d required 0/0100/2", i, s_axis_tready, lane_rvalid, in_cnt);
         end
      end
      lane_hold = 4'b0000;
      wait_done(400, ok);
      n_tests++;
      if (!ok || got_data.size() != 32) begin
         n_fail++;
         $display("FAIL lstall_done: done=%0d beats=%0d required 1/32", ok, got_data.size());
      end else begin
         for (int n = 0; n < 32; n++) begin
            n_tests++;
            if (got_data[n] !== exp_beat(64, n)) begin
               n_fail++;
               $display("FAIL lstall_beat%0d: got %h required %h", n, got_data[n], exp_beat(64, n));
            end
         end
      end
      n_tests++;
      if (in_cnt !== 8) begin
         n_fail++;
         $display("FAIL lstall_in_cnt: got %0d required 8", in_cnt);
      end
   endtask

   task automatic test_out_stall();
      bit ok;
      bit hit;
      logic [c_dw-1:0] snap_d;
      logic [c_cw-1:0] snap_c;
      clear_capture();
      load_src(100, 0, 8);
      pulse_start(8, 32);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #2;
         if (out_cnt >= 4) begin
            hit = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!hit) begin
         n_fail++;
         $display("FAIL ostall_reach: out_cnt=%0d required >=4", out_cnt);
      end
      sink_ready = 1'b0;
      @(negedge clk); #2;
      snap_d = m_axis_tdata;
      snap_c = out_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #2;
         n_tests++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== snap_d || out_cnt !== snap_c) begin
            n_fail++;
            $display("FAIL ostall_stable%0d: got v=%b d=%h cnt=%0d required 1/%h/%0d", i, m_axis_tvalid, m_axis_tdata, out_cnt, snap_d, snap_c);
         end
      end
      n_tests++;
      if (lane_wready !== 4'b0000 || lane_wvalid !== 4'b1111) begin
         n_fail++;
         $display("FAIL ostall_full: got wready=%b wvalid=%b required 0000/1111", lane_wready, lane_wvalid);
      end
      sink_ready = 1'b1;
      wait_done(400, ok);
      n_tests++;
      if (!ok || got_data.size() != 32) begin
         n_fail++;
         $display("FAIL ostall_done: done=%0d beats=%0d required 1/32", ok, got_data.size());
      end else begin
         for (int n = 0; n < 32; n++) begin
            n_tests++;
            if (got_data[n] !== exp_beat(100, n)) begin
               n_fail++;
               $display("FAIL ostall_beat%0d: got %h required %h", n, got_data[n], exp_beat(100, n));
            end
         end
      end
   endtask

   task automatic test_ignored_start();
      bit ok;
      bit hit;
      int d0;
      d0 = done_cnt;
      pulse_start(0, 32);
      repeat (3) @(negedge clk);
      #2;
      n_tests++;
      if (busy !== 1'b0 || done_cnt != d0) begin
         n_fail++;
         $display("FAIL zero_in_total: got busy=%b dones=%0d required 0/%0d", busy, done_cnt, d0);
      end
      pulse_start(8, 0);
      repeat (3) @(negedge clk);
      #2;
      n_tests++;
      if (busy !== 1'b0 || done_cnt != d0) begin
         n_fail++;
         $display("FAIL zero_out_total: got busy=%b dones=%0d required 0/%0d", busy, done_cnt, d0);
      end
      clear_capture();
      load_src(200, 0, 3);
      pulse_start(8, 32);
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #2;
         if (in_cnt == 3) begin
            hit = 1'b1;
            break;
         end
      end
      pulse_start(2, 2);
      n_tests++;
      if (!hit || in_cnt !== 3 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_in_run: got in=%0d busy=%b required 3/1", in_cnt, busy);
      end
      load_src(200, 3, 5);
      wait_done(400, ok);
      n_tests++;
      if (!ok || got_data.size() != 32) begin
         n_fail++;
         $display("FAIL restart_done: done=%0d beats=%0d required 1/32", ok, got_data.size());
      end else begin
         for (int n = 0; n < 32; n++) begin
            n_tests++;
            if (got_data[n] !== exp_beat(200, n) || got_last[n] !== (n == 31)) begin
               n_fail++;
               $display("FAIL restart_beat%0d: got %h/%b required %h/%b", n, got_data[n], got_last[n], exp_beat(200, n), n == 31);
            end
         end
      end
      n_tests++;
      if (in_cnt !== 8) begin
         n_fail++;
         $display("FAIL restart_in_cnt: got %0d required 8", in_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      bit ok;
      bit hit;
      int d0;
      clear_capture();
      load_src(300, 0, 8);
      pulse_start(8, 32);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #2;
         if (out_cnt == 5) begin
            hit = 1'b1;
            break;
         end
      end
      d0  = done_cnt;
      rst = 1'b1;
      #1;
      n_tests++;
      if (!hit || {busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 5'b0 ||
          {lane_rvalid, lane_wready} !== 8'h00 || in_cnt !== 0 || out_cnt !== 0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got ctl=%b lanes=%h in=%0d out=%0d required 00000/00/0/0",
                  {busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast}, {lane_rvalid, lane_wready}, in_cnt, out_cnt);
      end
      src_q.delete();
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      n_tests++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_no_done: got dones=%0d busy=%b required %0d/0", done_cnt, busy, d0);
      end
      clear_capture();
      load_src(400, 0, 8);
      pulse_start(8, 32);
      wait_done(400, ok);
      n_tests++;
      if (!ok || got_data.size() != 32) begin
         n_fail++;
         $display("FAIL midrst_refr_done: done=%0d beats=%0d required 1/32", ok, got_data.size());
      end else begin
         for (int n = 0; n < 32; n++) begin
            n_tests++;
            if (got_data[n] !== exp_beat(400, n) || got_last[n] !== (n == 31)) begin
               n_fail++;
               $display("FAIL midrst_beat%0d: got %h/%b required %h/%b", n, got_data[n], got_last[n], exp_beat(400, n), n == 31);
            end
         end
      end
      n_tests++;
      if (in_cnt !== 8 || out_cnt !== 32) begin
         n_fail++;
         $display("FAIL midrst_counts: got in=%0d out=%0d required 8/32", in_cnt, out_cnt);
      end
   endtask

`ifdef AC_LANE_PERF_EN
   task automatic test_perf();
      bit ok;
      bit hit;
      clear_capture();
      load_src(500, 0, 8);
      pulse_start(8, 32);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #2;
         if (out_cnt >= 4 && m_axis_tvalid === 1'b1) begin
            hit = 1'b1;
            break;
         end
      end
      sink_ready = 1'b0;
      repeat (7) @(negedge clk);
      #2;
      sink_ready = 1'b1;
      wait_done(400, ok);
      n_tests++;
      if (!hit || !ok || perf_ostall !== 7) begin
         n_fail++;
         $display("FAIL perf_ostall: got %0d (done=%0d) required 7", perf_ostall, ok);
      end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      in_total   = '0;
      out_total  = '0;
      sink_ready = 1'b1;
      lane_hold  = 4'b0000;
      test_reset();
      test_frame();
      test_lane_stall();
      test_out_stall();
      test_ignored_start();
      test_reset_midframe();
`ifdef AC_LANE_PERF_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ac_lane_dispatcher
`default_nettype wire
